// File: rtl/pkmc_wbmemctrl_regiondec_if.sv
// rtl/pkmc_wbmemctrl_regiondec_if.sv - Wishbone slave / memory-controller signal bundle for the region decoder
interface pkmc_wbmemctrl_regiondec_if #(
  parameter int NUM_MEMS = 3,
  parameter int ADDR_W   = 32,
  parameter int SEL_W    = 2
);
  logic                cyc_i;
  logic                stb_i;
  logic [ADDR_W-1:0]   addr_i;
  logic                mem_ack_i;
  logic                refresh_req_i;
  logic                refresh_ack_o;
  logic [NUM_MEMS-1:0] active_o;
  logic [SEL_W-1:0]    mux_sel_o;
  logic                err_o;
  logic                timeout_o;

  // Bus side: drives the Wishbone cycle, memory ack and refresh request.
  modport master (
    output cyc_i, stb_i, addr_i, mem_ack_i, refresh_req_i,
    input  refresh_ack_o, active_o, mux_sel_o, err_o, timeout_o
  );

  // Decoder side.
  modport slave (
    input  cyc_i, stb_i, addr_i, mem_ack_i, refresh_req_i,
    output refresh_ack_o, active_o, mux_sel_o, err_o, timeout_o
  );
endinterface

// File: rtl/pkmc_wbmemctrl_regiondec.sv
// rtl/pkmc_wbmemctrl_regiondec.sv - Wishbone region decoder, cycle lock, refresh arbiter and bus watchdog
module pkmc_wbmemctrl_regiondec #(
  parameter int                         NUM_MEMS    = 3,
  parameter int                         ADDR_W      = 32,
  parameter int                         SEL_W       = 2,
  parameter logic [NUM_MEMS*ADDR_W-1:0] REGION_BASE = {32'hF000_0000, 32'h0000_0000, 32'h2000_0000},
  parameter logic [NUM_MEMS*ADDR_W-1:0] REGION_MASK = {32'hFF00_0000, 32'hFC00_0000, 32'hFFF0_0000},
  parameter int                         REFRESH_MEM = 1,
  parameter int                         TO_W        = 8,
  parameter int                         TIMEOUT     = 255
) (
  input logic                         clk,
  input logic                         rst_n,
  pkmc_wbmemctrl_regiondec_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ERROR,
    S_REFRESH
  } state_t;

  // Watchdog terminal count; only meaningful when TIMEOUT is non-zero.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [SEL_W-1:0]    r_idx;
  logic [SEL_W-1:0]    r_mux_sel;
  logic [TO_W-1:0]     r_wd;
  logic                r_err;
  logic                r_timeout;
  logic                r_refresh_ack;

  logic                w_req;
  logic                w_hit;
  logic [SEL_W-1:0]    w_hit_idx;
  logic                w_wd_expire;
  logic [NUM_MEMS-1:0] w_active;

  assign w_req       = bus.cyc_i & bus.stb_i;
  assign w_wd_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);

  // Base/mask match; scanning from the top down lets the lowest matching index win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_MEMS - 1; i >= 0; i--) begin
      if ((bus.addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit     = 1'b1;
        w_hit_idx = SEL_W'(i);
      end
    end
  end

  // Enable follows the locked region but is withdrawn whenever the master drops stb or cyc.
  always_comb begin
    w_active = '0;
    if (r_state == S_ACTIVE && w_req) begin
      w_active = NUM_MEMS'(1) << r_idx;
    end
  end

  // Cycle FSM: decode in IDLE, lock the region in ACTIVE, one-cycle ERROR, REFRESH only between cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_mux_sel     <= '0;
      r_wd          <= '0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
      r_refresh_ack <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.refresh_req_i) begin
            r_state       <= S_REFRESH;
            r_refresh_ack <= 1'b1;
            r_mux_sel     <= SEL_W'(REFRESH_MEM);
          end else if (w_req) begin
            if (w_hit) begin
              r_state   <= S_ACTIVE;
              r_idx     <= w_hit_idx;
              r_mux_sel <= w_hit_idx;
              r_wd      <= '0;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          // An ack in the watchdog terminal cycle still completes the cycle cleanly.
          if (bus.mem_ack_i || !bus.cyc_i) begin
            r_state <= S_IDLE;
          end else if (w_wd_expire) begin
            r_state   <= S_ERROR;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end else if (r_wd != '1) begin
            r_wd <= r_wd + TO_W'(1);
          end
        end
        S_ERROR: begin
          r_state <= S_IDLE;
        end
        S_REFRESH: begin
          if (!bus.refresh_req_i) begin
            r_state       <= S_IDLE;
            r_refresh_ack <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.active_o      = w_active;
  assign bus.mux_sel_o     = r_mux_sel;
  assign bus.err_o         = r_err;
  assign bus.timeout_o     = r_timeout;
  assign bus.refresh_ack_o = r_refresh_ack;

endmodule

// File: tb/tb_pkmc_wbmemctrl_regiondec.sv
// tb/tb_pkmc_wbmemctrl_regiondec.sv - Bench for the Wishbone region decoder
module tb_pkmc_wbmemctrl_regiondec;

  localparam int TIMEOUT = 4;

  localparam logic [31:0] A_SR  = 32'h2000_0010;
  localparam logic [31:0] A_SR0 = 32'h2000_0000;
  localparam logic [31:0] A_SD  = 32'h0000_1000;
  localparam logic [31:0] A_SD2 = 32'h0000_0040;
  localparam logic [31:0] A_FL  = 32'hF000_0000;
  localparam logic [31:0] A_UN  = 32'h8000_0000;

  typedef struct {
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic [31:0] addr;
    logic        ack;
    logic        req;
    logic [2:0]  e_act;
    logic [1:0]  e_sel;
    logic        e_err;
    logic        e_tmo;
    logic        e_rack;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  pkmc_wbmemctrl_regiondec_if #(.NUM_MEMS(3), .ADDR_W(32), .SEL_W(2)) bus ();

  pkmc_wbmemctrl_regiondec #(
    .NUM_MEMS(3), .ADDR_W(32), .SEL_W(2),
    .REFRESH_MEM(1), .TO_W(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region map written out as SRAM, SDRAM, FLASH.
  logic [31:0] m_base [3];
  logic [31:0] m_mask [3];

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic rn, input logic cyc, input logic stb, input logic [31:0] addr,
                              input logic ack, input logic req, input logic [2:0] ea, input logic [1:0] es,
                              input logic ee, input logic et, input logic er);
    vec_t v;
    v.rst_n = rn; v.cyc = cyc; v.stb = stb; v.addr = addr; v.ack = ack; v.req = req;
    v.e_act = ea; v.e_sel = es; v.e_err = ee; v.e_tmo = et; v.e_rack = er;
    return v;
  endfunction

  task automatic drive(input logic rn, input logic cyc, input logic stb, input logic [31:0] addr,
                       input logic ack, input logic req);
    rst_n             = rn;
    bus.cyc_i         = cyc;
    bus.stb_i         = stb;
    bus.addr_i        = addr;
    bus.mem_ack_i     = ack;
    bus.refresh_req_i = req;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {bus.active_o, bus.mux_sel_o, bus.err_o, bus.timeout_o, bus.refresh_ack_o};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got act/sel/err/tmo/rack=%b required %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs mid-cycle and check what the decoder shows before the next edge.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v.rst_n, v.cyc, v.stb, v.addr, v.ack, v.req);
    #1;
    check(name, {v.e_act, v.e_sel, v.e_err, v.e_tmo, v.e_rack});
  endtask

  // Reference model state: phase 0 idle, 1 bus cycle, 2 error, 3 refresh.
  int   m_phase, m_region, m_age, m_sel;
  bit   m_tflag;

  task automatic model_reset();
    m_phase = 0; m_region = 0; m_age = 0; m_sel = 0; m_tflag = 0;
  endtask

  task automatic model_advance(input logic rn, input logic cyc, input logic stb, input logic [31:0] addr,
                               input logic ack, input logic req);
    int r;
    if (!rn) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        if (req) begin
          m_phase = 3; m_sel = 1;
        end else if (cyc && stb) begin
          r = decode(addr);
          if (r >= 0) begin
            m_phase = 1; m_region = r; m_sel = r; m_age = 0;
          end else begin
            m_phase = 2; m_tflag = 0;
          end
        end
      end
      1: begin
        if (ack || !cyc) begin
          m_phase = 0;
        end else begin
          m_age++;
          if (TIMEOUT != 0 && m_age == TIMEOUT) begin
            m_phase = 2; m_tflag = 1;
          end
        end
      end
      2: m_phase = 0;
      default: if (!req) m_phase = 0;
    endcase
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 32'h2000_0000 | ($urandom & 32'h000F_FFFF);
      1: return $urandom & 32'h03FF_FFFF;
      2: return 32'hF000_0000 | ($urandom & 32'h00FF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        rn, cyc, stb, ack, req;
    logic [31:0] addr;
    logic [2:0]  e_act;

    n_checks = 0;
    n_fail   = 0;
    m_base[0] = 32'h2000_0000; m_mask[0] = 32'hFFF0_0000;
    m_base[1] = 32'h0000_0000; m_mask[1] = 32'hFC00_0000;
    m_base[2] = 32'hF000_0000; m_mask[2] = 32'hFF00_0000;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Directed scenarios, one row per clock.
    tbl.push_back(mk(0,0,0,0,0,0,     3'd0,2'd0,0,0,0));
    // SRAM read, ack three cycles after enable
    tbl.push_back(mk(1,1,1,A_SR,0,0,  3'd0,2'd0,0,0,0));
    tbl.push_back(mk(1,1,1,A_SR,0,0,  3'd1,2'd0,0,0,0));
    tbl.push_back(mk(1,1,1,A_SR,0,0,  3'd1,2'd0,0,0,0));
    tbl.push_back(mk(1,1,1,A_SR,0,0,  3'd1,2'd0,0,0,0));
    tbl.push_back(mk(1,1,1,A_SR,1,0,  3'd1,2'd0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,0,0,0));
    // Unmapped address
    tbl.push_back(mk(1,1,1,A_UN,0,0,  3'd0,2'd0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,0,0,0));
    // Refresh and SDRAM request in the same IDLE cycle
    tbl.push_back(mk(1,1,1,A_SD,0,1,  3'd0,2'd0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1,1,1,A_SD,0,1, 3'd0,2'd1,0,0,1));
    tbl.push_back(mk(1,1,1,A_SD,0,0,  3'd0,2'd1,0,0,1));
    tbl.push_back(mk(1,1,1,A_SD,0,0,  3'd0,2'd1,0,0,0));
    tbl.push_back(mk(1,1,1,A_SD,1,0,  3'd2,2'd1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,0));
    // Refresh deferred behind a FLASH cycle
    tbl.push_back(mk(1,1,1,A_FL,0,0,  3'd0,2'd1,0,0,0));
    tbl.push_back(mk(1,1,1,A_FL,0,1,  3'd4,2'd2,0,0,0));
    tbl.push_back(mk(1,1,1,A_FL,0,1,  3'd4,2'd2,0,0,0));
    tbl.push_back(mk(1,1,1,A_FL,1,1,  3'd4,2'd2,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,     3'd0,2'd2,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,     3'd0,2'd1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,0));
    // Watchdog expiry on an SDRAM cycle, cyc dropped during ERROR
    tbl.push_back(mk(1,1,1,A_SD2,0,0, 3'd0,2'd1,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1,1,1,A_SD2,0,0, 3'd2,2'd1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,0));
    // Ack on the watchdog terminal cycle wins
    tbl.push_back(mk(1,1,1,A_SD2,0,0, 3'd0,2'd1,0,0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,1,A_SD2,0,0, 3'd2,2'd1,0,0,0));
    tbl.push_back(mk(1,1,1,A_SD2,1,0, 3'd2,2'd1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,0));
    // Abort mid-cycle, then prove IDLE by decoding an unmapped address
    tbl.push_back(mk(1,1,1,A_SR0,0,0, 3'd0,2'd1,0,0,0));
    tbl.push_back(mk(1,1,1,A_SR0,0,0, 3'd1,2'd0,0,0,0));
    tbl.push_back(mk(1,0,0,A_SR0,0,0, 3'd0,2'd0,0,0,0));
    tbl.push_back(mk(1,1,1,A_UN,0,0,  3'd0,2'd0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,0,0,0));
    // Reset while in REFRESH
    tbl.push_back(mk(1,0,0,0,0,1,     3'd0,2'd0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,     3'd0,2'd1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,1,     3'd0,2'd1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,     3'd0,2'd0,0,0,0));

    repeat (2) @(negedge clk);
    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k]);

    // Back-to-back cycles with stb held: ack, idle, active
    step("b2b_idle0",   mk(1,1,1,A_SR0,0,0, 3'd0,2'd0,0,0,0));
    step("b2b_act0",    mk(1,1,1,A_SR0,1,0, 3'd1,2'd0,0,0,0));
    step("b2b_idle1",   mk(1,1,1,A_SD,0,0,  3'd0,2'd0,0,0,0));
    step("b2b_act1",    mk(1,1,1,A_SD,1,0,  3'd2,2'd1,0,0,0));
    step("b2b_done",    mk(1,0,0,0,0,0,     3'd0,2'd1,0,0,0));

    // Randomized traffic against the reference model, starting from reset
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    model_reset();
    req = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rn   = ($urandom_range(0, 299) != 0);
      cyc  = ($urandom_range(0, 9) != 0);
      stb  = cyc ? ($urandom_range(0, 4) != 0) : $urandom_range(0, 1) == 1;
      addr = rand_addr();
      ack  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 14) == 0) req = ~req;
      @(negedge clk);
      drive(rn, cyc, stb, addr, ack, req);
      #1;
      e_act = (m_phase == 1 && cyc && stb) ? (3'b001 << m_region) : 3'b000;
      check($sformatf("rand%0d", c),
            {e_act, 2'(m_sel), m_phase == 2, m_phase == 2 && m_tflag, m_phase == 3});
      @(posedge clk);
      model_advance(rn, cyc, stb, addr, ack, req);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
